// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester RAM arbiter.
package mem_arbiter_pkg;

    localparam int ARB_AW            = 8;
    localparam int ARB_DW            = 8;
    localparam int ARB_CPU_BURST_MAX = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_LDR = 1'b1
    } owner_t;

    // Width needed to count CPU grants from 0 up to burst_max inclusive.
    function automatic int burst_cnt_width(input int burst_max);
        return (burst_max < 1) ? 1 : $clog2(burst_max + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner select: CPU has fixed priority unless the loader has
// already watched CPU_BURST_MAX CPU grants go by while it was waiting.
module arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int CPU_BURST_MAX = ARB_CPU_BURST_MAX,
    parameter int CNT_W         = burst_cnt_width(CPU_BURST_MAX)
) (
    input  logic             cpu_req,
    input  logic             ldr_req,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             grant_cpu,
    output logic             grant_ldr
);

    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(CPU_BURST_MAX);

    // Loader wins when the CPU is quiet or the starvation guard has tripped.
    always_comb begin
        grant_ldr = ldr_req && (!cpu_req || (burst_cnt == BURST_LIMIT));
        grant_cpu = cpu_req && !grant_ldr;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM between the CPU and the program loader.
// One access every two cycles: ACCESS drives the RAM, RESP waits for the
// read data and re-arbitrates on its exit edge.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW            = ARB_AW,
    parameter int DW            = ARB_DW,
    parameter int CPU_BURST_MAX = ARB_CPU_BURST_MAX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int               CNT_W       = burst_cnt_width(CPU_BURST_MAX);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(CPU_BURST_MAX);

    arb_state_t       state_reg;
    owner_t           owner_reg;
    logic [CNT_W-1:0] burst_cnt_reg;
    logic             mem_en_reg;
    logic             mem_we_reg;
    logic [AW-1:0]    mem_addr_reg;
    logic [DW-1:0]    mem_wdata_reg;
    logic             cpu_gnt_reg;
    logic             ldr_gnt_reg;
    logic             cpu_rvalid_reg;
    logic             ldr_rvalid_reg;
    logic [DW-1:0]    cpu_rdata_reg;
    logic [DW-1:0]    ldr_rdata_reg;

    logic             grant_cpu;
    logic             grant_ldr;
    logic             arb_slot;
    logic             win_cpu;
    logic             win_ldr;

    arb_pick #(
        .CPU_BURST_MAX (CPU_BURST_MAX),
        .CNT_W         (CNT_W)
    ) u_pick (
        .cpu_req   (cpu_req),
        .ldr_req   (ldr_req),
        .burst_cnt (burst_cnt_reg),
        .grant_cpu (grant_cpu),
        .grant_ldr (grant_ldr)
    );

    // Requests are only looked at on edges leaving IDLE or RESP.
    assign arb_slot = (state_reg != ARB_ACCESS);
    assign win_cpu  = arb_slot && grant_cpu;
    assign win_ldr  = arb_slot && grant_ldr;

    // Arbiter FSM: latch the winner's access, drive the RAM for one cycle,
    // then return read data to whoever owned the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ARB_IDLE;
            owner_reg      <= OWNER_CPU;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            cpu_gnt_reg    <= 1'b0;
            ldr_gnt_reg    <= 1'b0;
            cpu_rvalid_reg <= 1'b0;
            ldr_rvalid_reg <= 1'b0;
            cpu_rdata_reg  <= '0;
            ldr_rdata_reg  <= '0;
        end else begin
            mem_en_reg     <= 1'b0;
            cpu_gnt_reg    <= 1'b0;
            ldr_gnt_reg    <= 1'b0;
            cpu_rvalid_reg <= 1'b0;
            ldr_rvalid_reg <= 1'b0;

            // RAM read data is valid during RESP; hand it to the old owner.
            if ((state_reg == ARB_RESP) && !mem_we_reg) begin
                if (owner_reg == OWNER_LDR) begin
                    ldr_rdata_reg  <= mem_rdata;
                    ldr_rvalid_reg <= 1'b1;
                end else begin
                    cpu_rdata_reg  <= mem_rdata;
                    cpu_rvalid_reg <= 1'b1;
                end
            end

            if (win_cpu || win_ldr) begin
                state_reg     <= ARB_ACCESS;
                owner_reg     <= win_ldr ? OWNER_LDR : OWNER_CPU;
                mem_en_reg    <= 1'b1;
                mem_we_reg    <= win_ldr ? ldr_we    : cpu_we;
                mem_addr_reg  <= win_ldr ? ldr_addr  : cpu_addr;
                mem_wdata_reg <= win_ldr ? ldr_wdata : cpu_wdata;
                cpu_gnt_reg   <= win_cpu;
                ldr_gnt_reg   <= win_ldr;
            end else if (state_reg == ARB_ACCESS) begin
                state_reg <= ARB_RESP;
            end else begin
                state_reg <= ARB_IDLE;
            end
        end
    end

    // Starvation guard: count CPU grants that overtake a waiting loader.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt_reg <= '0;
        end else if (!ldr_req || win_ldr) begin
            burst_cnt_reg <= '0;
        end else if (win_cpu && (burst_cnt_reg != BURST_LIMIT)) begin
            burst_cnt_reg <= burst_cnt_reg + 1'b1;
        end
    end

    assign cpu_gnt    = cpu_gnt_reg;
    assign ldr_gnt    = ldr_gnt_reg;
    assign cpu_rvalid = cpu_rvalid_reg;
    assign ldr_rvalid = ldr_rvalid_reg;
    assign cpu_rdata  = cpu_rdata_reg;
    assign ldr_rdata  = ldr_rdata_reg;
    assign mem_en     = mem_en_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign busy       = (state_reg != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the arbitration
// rules and a shadow copy of the RAM contents.
module tb_mem_arbiter;

    localparam int BURST_MAX = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, ldr_req, ldr_we;
    logic [7:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic       cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid;
    logic [7:0] cpu_rdata, ldr_rdata;
    logic       mem_en, mem_we, busy;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.AW(8), .DW(8), .CPU_BURST_MAX(BURST_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Synchronous 256x8 RAM seen by the arbiter.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // ---------------- reference model state ----------------
    typedef struct packed {
        logic       valid;
        logic       to_ldr;
        logic [7:0] data;
    } rd_t;

    logic [7:0] ref_mem [256];
    int         cur_win;        // grant seen this cycle: 0 none, 1 CPU, 2 loader
    int         overtakes;      // CPU grants since the loader started waiting
    rd_t        prev_rd, cur_rd;
    logic [7:0] exp_cpu_rdata, exp_ldr_rdata;
    int         n_cpu_gnt, n_ldr_gnt;
    int         errors = 0;
    int         checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cur_win       = 0;
        overtakes     = 0;
        prev_rd       = '0;
        cur_rd        = '0;
        exp_cpu_rdata = 8'h00;
        exp_ldr_rdata = 8'h00;
    endtask

    // Advance one clock: predict the next grant from the arbitration rules,
    // then compare every DUT output. Granted requesters drop their request.
    task automatic do_cycle();
        int         win;
        logic       w_we;
        logic [7:0] w_addr, w_data;
        logic       exp_busy;
        rd_t        rv;
        win = 0;
        // The cycle after a grant is the RAM access itself: no arbitration.
        if (cur_win == 0) begin
            if (ldr_req && (!cpu_req || overtakes == BURST_MAX)) win = 2;
            else if (cpu_req)                                     win = 1;
        end
        if (!ldr_req || win == 2)                      overtakes = 0;
        else if (win == 1 && overtakes < BURST_MAX)    overtakes++;
        w_we     = (win == 2) ? ldr_we    : cpu_we;
        w_addr   = (win == 2) ? ldr_addr  : cpu_addr;
        w_data   = (win == 2) ? ldr_wdata : cpu_wdata;
        exp_busy = (win != 0) || (cur_win != 0);

        tick();

        check1("cpu_gnt", cpu_gnt, win == 1);
        check1("ldr_gnt", ldr_gnt, win == 2);
        check1("mem_en",  mem_en,  win != 0);
        check1("busy",    busy,    exp_busy);
        if (win != 0) begin
            check1("mem_we",    mem_we,    w_we);
            check8("mem_addr",  mem_addr,  w_addr);
            check8("mem_wdata", mem_wdata, w_data);
        end
        rv = prev_rd;
        if (rv.valid && !rv.to_ldr) exp_cpu_rdata = rv.data;
        if (rv.valid &&  rv.to_ldr) exp_ldr_rdata = rv.data;
        check1("cpu_rvalid", cpu_rvalid, rv.valid && !rv.to_ldr);
        check1("ldr_rvalid", ldr_rvalid, rv.valid &&  rv.to_ldr);
        check8("cpu_rdata",  cpu_rdata,  exp_cpu_rdata);
        check8("ldr_rdata",  ldr_rdata,  exp_ldr_rdata);

        prev_rd = cur_rd;
        cur_rd  = '0;
        if (win != 0) begin
            if (w_we) ref_mem[w_addr] = w_data;
            else      cur_rd = '{valid: 1'b1, to_ldr: (win == 2), data: ref_mem[w_addr]};
            $display("t=%0t grant %s we=%0b addr=%02h wdata=%02h",
                     $time, (win == 2) ? "LDR" : "CPU", w_we, w_addr, w_data);
        end
        if (win == 1) begin n_cpu_gnt++; cpu_req = 1'b0; end
        if (win == 2) begin n_ldr_gnt++; ldr_req = 1'b0; end
        cur_win = win;
    endtask

    task automatic set_cpu(input logic we, input logic [7:0] addr, input logic [7:0] data);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    endtask

    task automatic set_ldr(input logic we, input logic [7:0] addr, input logic [7:0] data);
        ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = data;
    endtask

    initial begin
        int base, idx, runs_n, since;
        int runs [2];
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'((i * 7) + 3);
            ref_mem[i] = 8'((i * 7) + 3);
        end
        ram[8'h10]     = 8'hA5;
        ref_mem[8'h10] = 8'hA5;
        mem_rdata = 8'h00;
        reset   = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 8'h00; ldr_wdata = 8'h00;
        n_cpu_gnt = 0; n_ldr_gnt = 0;
        model_reset();

        // Reset state
        tick(); tick();
        check1("rst_mem_en", mem_en, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_cpu_gnt", cpu_gnt, 1'b0);
        check1("rst_ldr_gnt", ldr_gnt, 1'b0);
        check8("rst_mem_addr", mem_addr, 8'h00);
        check8("rst_cpu_rdata", cpu_rdata, 8'h00);
        check8("rst_ldr_rdata", ldr_rdata, 8'h00);
        reset = 1'b1;
        do_cycle();

        // 1: CPU read of 0x10 returns 0xA5 two cycles after the grant
        set_cpu(1'b0, 8'h10, 8'h00);
        do_cycle();
        check1("t1_gnt", cpu_gnt, 1'b1);
        check8("t1_addr", mem_addr, 8'h10);
        do_cycle(); do_cycle();
        check1("t1_rvalid", cpu_rvalid, 1'b1);
        check8("t1_rdata", cpu_rdata, 8'hA5);
        do_cycle();

        // 2: loader writes 0x3C at 0x80, CPU reads it back
        set_ldr(1'b1, 8'h80, 8'h3C);
        do_cycle(); do_cycle();
        set_cpu(1'b0, 8'h80, 8'h00);
        repeat (4) do_cycle();
        check8("t2_rdata", cpu_rdata, 8'h3C);

        // 3: simultaneous requests with no backlog: CPU first, then loader
        set_cpu(1'b0, 8'h05, 8'h00);
        set_ldr(1'b0, 8'h06, 8'h00);
        do_cycle();
        check1("t3_cpu_first", cpu_gnt, 1'b1);
        do_cycle(); do_cycle();
        check1("t3_ldr_next", ldr_gnt, 1'b1);
        repeat (3) do_cycle();

        // 4: both held: four CPU grants, then the loader, twice in a row
        runs_n = 0; since = 0; base = n_ldr_gnt;
        runs[0] = -1; runs[1] = -1;
        set_cpu(1'b0, 8'h20, 8'h00);
        set_ldr(1'b1, 8'h90, 8'h11);
        for (int c = 0; c < 24; c++) begin
            idx = n_cpu_gnt;
            do_cycle();
            if (n_cpu_gnt != idx) since++;
            if (ldr_gnt) begin
                if (runs_n < 2) runs[runs_n] = since;
                runs_n++;
                since = 0;
                if (runs_n < 2) set_ldr(1'b1, 8'h91, 8'h22);
            end
            if (!cpu_req && c < 20) set_cpu(1'b0, 8'(8'h20 + c), 8'h00);
        end
        check8("t4_run0", 8'(runs[0]), 8'd4);
        check8("t4_run1", 8'(runs[1]), 8'd4);
        repeat (4) do_cycle();

        // 5: back-to-back CPU reads of 0x00..0x03
        base = n_cpu_gnt; idx = 1;
        set_cpu(1'b0, 8'h00, 8'h00);
        for (int c = 0; c < 8; c++) begin
            do_cycle();
            if (!cpu_req && idx < 4) begin
                set_cpu(1'b0, 8'(idx), 8'h00);
                idx++;
            end
        end
        check8("t5_gnts", 8'(n_cpu_gnt - base), 8'd4);
        repeat (3) do_cycle();

        // 6: reset in the middle of a CPU write drops it immediately
        set_cpu(1'b1, 8'h20, 8'hEE);
        tick();
        check1("t6_gnt", cpu_gnt, 1'b1);
        check1("t6_mem_en", mem_en, 1'b1);
        cpu_req = 1'b0;
        #1 reset = 1'b0;
        #1;
        check1("t6_mem_en_rst", mem_en, 1'b0);
        check1("t6_gnt_rst", cpu_gnt, 1'b0);
        check1("t6_busy_rst", busy, 1'b0);
        check1("t6_we_rst", mem_we, 1'b0);
        check8("t6_addr_rst", mem_addr, 8'h00);
        check8("t6_rdata_rst", cpu_rdata, 8'h00);
        tick(); tick();
        reset = 1'b1;
        model_reset();
        set_cpu(1'b0, 8'h20, 8'h00);
        repeat (4) do_cycle();
        check8("t6_read_after", cpu_rdata, ref_mem[8'h20]);

        // Random traffic from both requesters
        for (int c = 0; c < 400; c++) begin
            if (!cpu_req && ($urandom_range(0, 2) == 0))
                set_cpu(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            if (!ldr_req && ($urandom_range(0, 3) == 0))
                set_ldr(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            do_cycle();
        end
        repeat (4) do_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
